sarray_left_skew_feeder: RTL and testbench
==========================================

// Module: sarray_left_skew_feeder
// PURPOSE
//  Upstream feeder for the systolic array's left edge: accepts one A-operand column vector
//  (one element per array row) per cycle over valid/ready.
//  Emits a row-skewed stream: row r delayed r cycles, so wavefronts meet top operands
//  diagonally. Drives the array's left_in_valid/cnt/type/precision/data buses.
//  After the last vector, drains the skew and pulses done.
// PARAMETERS
//  SARRAY_H   64  array rows = lanes (bench uses 4)
//  DATA_W     16  per-row element width (= PE_INPUT_DATA_WIDTH)
//  CNT_W      8   cnt tag width (= TMMA_CNT_WIDTH)
//  PREC_W     2   precision code width (= TMMA_PRECISION_WIDTH)
// PORTS
//  clk            in   1             clock
//  rst            in   1             async reset, active-high
//  in_valid_i     in   1             vector valid
//  in_ready_o     out  1             feeder can accept
//  in_last_i      in   1             final vector of tile
//  in_cnt_i       in   CNT_W         k-index tag, replicated to all rows
//  in_type_i      in   1             data type bit, replicated
//  in_precision_i in   PREC_W        precision, replicated
//  in_data_i      in   SARRAY_H*DATA_W  row r at [r*DATA_W +: DATA_W]
//  left_valid_o   out  SARRAY_H      per-row valid to array
//  left_cnt_o     out  SARRAY_H*CNT_W
//  left_type_o    out  SARRAY_H
//  left_prec_o    out  SARRAY_H*PREC_W
//  left_data_o    out  SARRAY_H*DATA_W
//  busy_o         out  1             state != IDLE
//  done_o         out  1             1-cycle pulse: last element left row SARRAY_H-1
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready_o=1 (state IDLE); all skew stages cleared.
//  Async reset asserted mid-tile: skew pipeline cleared immediately, no done pulse,
//  state IDLE.
//  Accept = in_valid_i & in_ready_o. in_ready_o = (state != DRAIN), combinational from
//  state.
//  Skew: row r has r+1 register stages (valid,cnt,type,prec,data); accepted at cycle t ->
//  row r emits at t+1+r. Non-accept cycle injects a bubble (valid 0) propagated through
//  skew identically.
//  No backpressure from array: pipeline advances every cycle.
//  FSM: IDLE --accept & !last--> FEED; IDLE/FEED --accept & last--> DRAIN;
//       FEED stays FEED on bubbles or non-last accepts;
//       DRAIN: counter loaded SARRAY_H-1 on entry, decrements each cycle;
//       at 0 -> done_o=1 that cycle, next IDLE.
//  Timing: last accepted at t -> DRAIN t+1..t+SARRAY_H, done_o at t+SARRAY_H (coincides
//  with row SARRAY_H-1 final valid), in_ready_o=1 again at t+SARRAY_H+1.
//  Single-vector tile (last on first accept) legal: IDLE->DRAIN directly.
//  SARRAY_H=1: DRAIN lasts 1 cycle, done coincides with row 0 output.
//  Drain counter width clog2(SARRAY_H)+1; never wraps.
//  in_last_i ignored when not accepted.
// CONFIGURATION
//  SKEW_FEEDER_ZERO_GATE_EN defined: left_data_o/cnt/prec/type lanes forced 0 when that
//    lane's valid is 0.
//  Undefined: invalid lanes carry whatever the stage holds (stale/bubble data, don't-care).
//  Valid, done and handshake timing identical in both builds.
// TESTING (SARRAY_H=4, DATA_W=16)
//  Single vector data {r3..r0}={4,3,2,1}, cnt=5, last=1 at t0 -> row r valid only at t0+1+r
//    with data r+1, cnt 5; done at t0+4; ready low t0+1..t0+4.
//  8 back-to-back vectors (last on 8th) -> each row shows 8 contiguous valids offset by r;
//    no loss or reorder; done 4 cycles after 8th accept.
//  Vectors at t0, t0+2 (bubble at t0+1) -> every row shows 1,0,1 valid pattern shifted by r.
//  in_valid held during DRAIN -> no accept, data held by source, accepted at t+5 after done.
//  rst pulsed while rows 1-3 still hold data -> all left_valid_o 0 immediately, busy 0,
//    no done.
//  ZERO_GATE build: bubble cycles show left_data_o lane=0; non-gated build: only valids
//    checked.

Source files
------------

// File: rtl/sarray_left_skew_feeder_if.sv
// Bus bundle between an A-operand source and the systolic array left-edge skew feeder.
// master: the vector source (drives in_*, observes the array-side outputs).
// slave:  the feeder itself.
interface sarray_left_skew_feeder_if #(
  parameter int SARRAY_H = 64,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 8,
  parameter int PREC_W   = 2
);
  // Column-vector input handshake
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic                       in_last_i;
  logic [CNT_W-1:0]           in_cnt_i;
  logic                       in_type_i;
  logic [PREC_W-1:0]          in_precision_i;
  logic [SARRAY_H*DATA_W-1:0] in_data_i;

  // Row-skewed buses into the array's left edge
  logic [SARRAY_H-1:0]        left_valid_o;
  logic [SARRAY_H*CNT_W-1:0]  left_cnt_o;
  logic [SARRAY_H-1:0]        left_type_o;
  logic [SARRAY_H*PREC_W-1:0] left_prec_o;
  logic [SARRAY_H*DATA_W-1:0] left_data_o;

  // Status
  logic                       busy_o;
  logic                       done_o;

  modport master (
    output in_valid_i, in_last_i, in_cnt_i, in_type_i, in_precision_i, in_data_i,
    input  in_ready_o, left_valid_o, left_cnt_o, left_type_o, left_prec_o, left_data_o,
    input  busy_o, done_o
  );

  modport slave (
    input  in_valid_i, in_last_i, in_cnt_i, in_type_i, in_precision_i, in_data_i,
    output in_ready_o, left_valid_o, left_cnt_o, left_type_o, left_prec_o, left_data_o,
    output busy_o, done_o
  );
endinterface

// File: rtl/sarray_left_skew_feeder.sv
// Left-edge skew feeder for the systolic array. Accepts one A-operand column per cycle
// and delays row r by r+1 register stages so operands enter the array diagonally.
// After the last vector of a tile it drains the skew and pulses done_o.
// Optional build macro SKEW_FEEDER_ZERO_GATE_EN: zero the data/cnt/type/prec lanes of
// any row whose valid is low. Valid, done and handshake timing are the same either way.
module sarray_left_skew_feeder #(
  parameter int SARRAY_H = 64,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 8,
  parameter int PREC_W   = 2
) (
  input  logic clk,
  input  logic rst,
  sarray_left_skew_feeder_if.slave bus
);
  // Wide enough to hold SARRAY_H-1 for any SARRAY_H >= 1.
  localparam int DCNT_W = $clog2(SARRAY_H) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic              accept;

  assign bus.in_ready_o = (state_q != ST_DRAIN);
  assign accept         = bus.in_valid_i & bus.in_ready_o;
  assign bus.busy_o     = (state_q != ST_IDLE);
  assign bus.done_o     = (state_q == ST_DRAIN) && (drain_cnt_q == '0);

  // Tile sequencing: feed until the last vector is taken, then count out the skew depth.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE, ST_FEED: begin
        if (accept) begin
          if (bus.in_last_i) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DCNT_W'(SARRAY_H - 1);
          end else begin
            state_d = ST_FEED;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = '0;
      end
    endcase
  end

  // FSM and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SARRAY_H; gi++) begin : g_row
      // Row gi delay line: stage 0 captures the input, stage gi drives the array.
      logic [gi:0]             vld_q, vld_d;
      logic [gi:0][DATA_W-1:0] dat_q, dat_d;
      logic [gi:0][CNT_W-1:0]  cnt_q, cnt_d;
      logic [gi:0]             typ_q, typ_d;
      logic [gi:0][PREC_W-1:0] prc_q, prc_d;

      // Advance the delay line every cycle; a non-accept cycle enters as a bubble.
      always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q;
        typ_d    = typ_q;
        prc_d    = prc_q;
        vld_d[0] = accept;
        dat_d[0] = bus.in_data_i[gi*DATA_W +: DATA_W];
        cnt_d[0] = bus.in_cnt_i;
        typ_d[0] = bus.in_type_i;
        prc_d[0] = bus.in_precision_i;
        for (int k = 1; k <= gi; k++) begin
          vld_d[k] = vld_q[k-1];
          dat_d[k] = dat_q[k-1];
          cnt_d[k] = cnt_q[k-1];
          typ_d[k] = typ_q[k-1];
          prc_d[k] = prc_q[k-1];
        end
      end

      // Delay-line registers; reset empties the whole row at once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          dat_q <= '0;
          cnt_q <= '0;
          typ_q <= '0;
          prc_q <= '0;
        end else begin
          vld_q <= vld_d;
          dat_q <= dat_d;
          cnt_q <= cnt_d;
          typ_q <= typ_d;
          prc_q <= prc_d;
        end
      end

      assign bus.left_valid_o[gi] = vld_q[gi];
`ifdef SKEW_FEEDER_ZERO_GATE_EN
      assign bus.left_data_o[gi*DATA_W +: DATA_W] = vld_q[gi] ? dat_q[gi] : '0;
      assign bus.left_cnt_o[gi*CNT_W +: CNT_W]    = vld_q[gi] ? cnt_q[gi] : '0;
      assign bus.left_type_o[gi]                  = vld_q[gi] & typ_q[gi];
      assign bus.left_prec_o[gi*PREC_W +: PREC_W] = vld_q[gi] ? prc_q[gi] : '0;
`else
      assign bus.left_data_o[gi*DATA_W +: DATA_W] = dat_q[gi];
      assign bus.left_cnt_o[gi*CNT_W +: CNT_W]    = cnt_q[gi];
      assign bus.left_type_o[gi]                  = typ_q[gi];
      assign bus.left_prec_o[gi*PREC_W +: PREC_W] = prc_q[gi];
`endif
    end
  endgenerate
endmodule

// File: tb/tb_sarray_left_skew_feeder.sv
// Scoreboard bench for sarray_left_skew_feeder (SARRAY_H=4, DATA_W=16).
// Accepted vectors push one expected entry per row, stamped with the cycle it must appear.
module tb_sarray_left_skew_feeder;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sarray_left_skew_feeder_if #(.SARRAY_H(H), .DATA_W(DW), .CNT_W(CW), .PREC_W(PW)) bus_if ();

  sarray_left_skew_feeder #(.SARRAY_H(H), .DATA_W(DW), .CNT_W(CW), .PREC_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
    logic          typ;
    logic [PW-1:0] prec;
  } exp_t;

  exp_t row_q [H][$];
  int   tests      = 0;
  int   fails      = 0;
  int   cyc        = 0;
  int   tile_first = -1;
  int   drain_end  = -1;
  bit   m_ready    = 1'b1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    bit   exp_busy;
    bit   exp_done;
    exp_t e;
    m_ready  = !(drain_end >= 0 && cyc > drain_end - H && cyc <= drain_end);
    exp_done = (drain_end >= 0 && cyc == drain_end);
    exp_busy = (tile_first >= 0 && cyc > tile_first && (drain_end < 0 || cyc <= drain_end));
    check("ready", 64'(bus_if.in_ready_o), 64'(m_ready));
    check("done",  64'(bus_if.done_o),     64'(exp_done));
    check("busy",  64'(bus_if.busy_o),     64'(exp_busy));
    for (int r = 0; r < H; r++) begin
      if (row_q[r].size() > 0 && row_q[r][0].cyc == cyc) begin
        e = row_q[r].pop_front();
        check($sformatf("row%0d_valid", r), 64'(bus_if.left_valid_o[r]), 64'd1);
        check($sformatf("row%0d_data", r),  64'(bus_if.left_data_o[r*DW +: DW]), 64'(e.data));
        check($sformatf("row%0d_cnt", r),   64'(bus_if.left_cnt_o[r*CW +: CW]), 64'(e.cnt));
        check($sformatf("row%0d_type", r),  64'(bus_if.left_type_o[r]), 64'(e.typ));
        check($sformatf("row%0d_prec", r),  64'(bus_if.left_prec_o[r*PW +: PW]), 64'(e.prec));
      end else begin
        check($sformatf("row%0d_valid", r), 64'(bus_if.left_valid_o[r]), 64'd0);
`ifdef SKEW_FEEDER_ZERO_GATE_EN
        check($sformatf("row%0d_gated_data", r), 64'(bus_if.left_data_o[r*DW +: DW]), 64'd0);
`endif
      end
    end
    if (exp_done) begin
      tile_first = -1;
      drain_end  = -1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  // Present a vector for the coming edge and record what it must produce if accepted.
  task automatic drive(input bit v, input bit last, input logic [CW-1:0] c, input bit t,
                       input logic [PW-1:0] p, input logic [H*DW-1:0] d, output bit acc);
    exp_t e;
    bus_if.in_valid_i     = v;
    bus_if.in_last_i      = last;
    bus_if.in_cnt_i       = c;
    bus_if.in_type_i      = t;
    bus_if.in_precision_i = p;
    bus_if.in_data_i      = d;
    acc = v && m_ready && !rst;
    if (acc) begin
      for (int r = 0; r < H; r++) begin
        e.cyc  = cyc + 1 + r;
        e.data = d[r*DW +: DW];
        e.cnt  = c;
        e.typ  = t;
        e.prec = p;
        row_q[r].push_back(e);
      end
      if (tile_first < 0) tile_first = cyc;
      if (last) drain_end = cyc + H;
      $display("[TB] cyc=%0d accept data=%h cnt=%0d last=%0b", cyc, d, c, last);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, '0, acc);
    end
  endtask

  initial begin
    bit acc;
    int n;
    logic [H*DW-1:0] d;

    bus_if.in_valid_i     = 1'b0;
    bus_if.in_last_i      = 1'b0;
    bus_if.in_cnt_i       = '0;
    bus_if.in_type_i      = 1'b0;
    bus_if.in_precision_i = '0;
    bus_if.in_data_i      = '0;

    // Reset state
    idle(2);
    rst = 1'b0;
    idle(1);

    // Single-vector tile
    tick();
    drive(1'b1, 1'b1, 8'd5, 1'b0, 2'd0, {16'd4, 16'd3, 16'd2, 16'd1}, acc);
    idle(6);

    // Eight back-to-back vectors
    for (int i = 0; i < 8; i++) begin
      tick();
      d = {$urandom, $urandom};
      drive(1'b1, i == 7, CW'(i + 16), i[0], i[1:0], d, acc);
    end
    idle(6);

    // Vector, bubble, last vector
    tick();
    drive(1'b1, 1'b0, 8'd9, 1'b1, 2'd2, {16'hA3, 16'hA2, 16'hA1, 16'hA0}, acc);
    idle(1);
    tick();
    drive(1'b1, 1'b1, 8'd10, 1'b0, 2'd3, {16'hB3, 16'hB2, 16'hB1, 16'hB0}, acc);
    idle(6);

    // Source holds valid through the drain window
    tick();
    drive(1'b1, 1'b1, 8'd1, 1'b0, 2'd1, {16'hC3, 16'hC2, 16'hC1, 16'hC0}, acc);
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      tick();
      drive(1'b1, 1'b1, 8'd2, 1'b1, 2'd2, {16'hD3, 16'hD2, 16'hD1, 16'hD0}, acc);
      n++;
    end
    check("hold_accept_bound", 64'(acc), 64'd1);
    idle(6);

    // Asynchronous reset while rows still hold data
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b1, 1'b0, CW'(i + 32), 1'b1, 2'd1, {16'hE0 + 16'(i), 16'hE1, 16'hE2, 16'hE3}, acc);
    end
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, '0, acc);
    #2 rst = 1'b1;
    #1;
    check("rst_valid_clear", 64'(bus_if.left_valid_o), 64'd0);
    check("rst_busy_clear",  64'(bus_if.busy_o), 64'd0);
    check("rst_no_done",     64'(bus_if.done_o), 64'd0);
    check("rst_ready",       64'(bus_if.in_ready_o), 64'd1);
    for (int r = 0; r < H; r++) row_q[r].delete();
    tile_first = -1;
    drain_end  = -1;
    idle(1);
    rst = 1'b0;
    idle(5);

    // Recovery after reset
    tick();
    drive(1'b1, 1'b1, 8'd7, 1'b1, 2'd3, {16'h44, 16'h33, 16'h22, 16'h11}, acc);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
